// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO, computes mult/div results
// at launch and commits them after a fixed busy window.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic        Req,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi, r_lo, r_hi_tmp, r_lo_tmp;
  logic          r_wr;

  logic          w_accept, w_move, w_is_div, w_div0;
  logic [63:0]   w_prod_s, w_prod_u;
  logic [31:0]   w_a_mag, w_b_mag, w_b_div, w_bu_div;
  logic [31:0]   w_q, w_r, w_quo_s, w_rem_s, w_quo_u, w_rem_u;
  logic [31:0]   w_hi_res, w_lo_res;

  assign Busy     = (r_cnt != '0);
  assign HI       = r_hi;
  assign LO       = r_lo;
  assign w_accept = Start && !Req && !Busy && (MDUOp <= 4'd3);
  // Start takes priority: moves raised together with Start are dropped.
  assign w_move   = !Start && !Req && !Busy;
  assign w_is_div = MDUOp[1];
  assign w_div0   = w_is_div && (B == 32'd0);

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_a_mag  = A[31] ? (~A + 32'd1) : A;
  assign w_b_mag  = B[31] ? (~B + 32'd1) : B;
  assign w_b_div  = (B == 32'd0) ? 32'd1 : w_b_mag;
  assign w_bu_div = (B == 32'd0) ? 32'd1 : B;
  assign w_q      = w_a_mag / w_b_div;
  assign w_r      = w_a_mag % w_b_div;
  assign w_quo_s  = (A[31] ^ B[31]) ? (~w_q + 32'd1) : w_q;
  assign w_rem_s  = A[31] ? (~w_r + 32'd1) : w_r;
  assign w_quo_u  = A / w_bu_div;
  assign w_rem_u  = A % w_bu_div;

  always_comb begin
    w_hi_res = w_prod_s[63:32];
    w_lo_res = w_prod_s[31:0];
    case (MDUOp[1:0])
      2'd1: begin w_hi_res = w_prod_u[63:32]; w_lo_res = w_prod_u[31:0]; end
      2'd2: begin w_hi_res = w_rem_s;         w_lo_res = w_quo_s;        end
      2'd3: begin w_hi_res = w_rem_u;         w_lo_res = w_quo_u;        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_hi_tmp <= '0;
      r_lo_tmp <= '0;
      r_wr     <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      r_hi_tmp <= w_hi_res;
      r_lo_tmp <= w_lo_res;
      r_wr     <= !w_div0;
    end else if (Busy) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1) && r_wr) begin
        r_hi <= r_hi_tmp;
        r_lo <= r_lo_tmp;
      end
    end else if (w_move) begin
      if (HIWrite) r_hi <= A;
      if (LOWrite) r_lo <= A;
    end
  end

endmodule
